// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake with retry
// on timeout, and presents the latched instruction (OP/Funct) to the control unit.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        advance,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] instr,
    output logic [5:0]  OP,
    output logic [5:0]  Funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      pc_nxt;
    logic [31:0]      instr_nxt;
    logic             req_nxt;
    logic             valid_nxt;
    logic             err_nxt;
    logic             timeout_hit;

    // Jump beats a taken branch; the branch offset is a signed word count.
    function automatic logic [31:0] next_pc(
        input logic [31:0] pc4,
        input logic [31:0] iw,
        input logic        jmp,
        input logic        br,
        input logic        zf
    );
        logic signed [31:0] offset;
        offset = {{14{iw[15]}}, iw[15:0], 2'b00};
        if (jmp)
            next_pc = {pc4[31:28], iw[25:0], 2'b00};
        else if (br && zf)
            next_pc = pc4 + $unsigned(offset);
        else
            next_pc = pc4;
    endfunction

    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    assign OP          = instr[31:26];
    assign Funct       = instr[5:0];
    // The current WAIT cycle is the TIMEOUT-th one without an ack.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_nxt    = pc;
        instr_nxt = instr;
        req_nxt   = imem_req;
        valid_nxt = instr_valid;
        err_nxt   = fetch_err;
        case (state)
            S_REQ: begin
                req_nxt   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    valid_nxt = 1'b1;
                    req_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_HOLD;
                end else if (timeout_hit) begin
                    err_nxt   = 1'b1;
                    req_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_REQ;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            S_HOLD: begin
                req_nxt = 1'b0;
                if (advance) begin
                    pc_nxt    = next_pc(pc_plus4, instr, Jump, Branch, Zero);
                    valid_nxt = 1'b0;
                    state_nxt = S_REQ;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                cnt_nxt   = '0;
                state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_REQ;
            cnt         <= '0;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            imem_req    <= req_nxt;
            fetch_err   <= err_nxt;
        end
    end

endmodule
